// File: rtl/sync_edge_array.sv
// Multi-channel input conditioner: synchroniser, programmable glitch filter,
// edge strobes, stretched pulses and sticky event flags per channel.
module sync_edge_array #(
  parameter int NCH        = 8,
  parameter int NSYNC      = 3,
  parameter int FILT_NB    = 4,
  parameter int STRETCH_NB = 3,
  parameter int EDGE_MODE  = 0
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [NCH-1:0]     in_i,
  input  logic [FILT_NB-1:0] filt_len_i,
  input  logic [NCH-1:0]     clear_i,
  output logic [NCH-1:0]     level_o,
  output logic [NCH-1:0]     edge_o,
  output logic [NCH-1:0]     stretch_o,
  output logic [NCH-1:0]     sticky_o,
  output logic               any_o
);

  (* ASYNC_REG = "TRUE" *) logic [NCH-1:0] sync_q [NSYNC];

  logic [NCH-1:0]        s;
  logic [FILT_NB-1:0]    fcnt_q [NCH];
  logic [FILT_NB-1:0]    fcnt_d [NCH];
  logic [STRETCH_NB-1:0] scnt_q [NCH];
  logic [STRETCH_NB-1:0] scnt_d [NCH];
  logic [NCH-1:0]        level_q, level_d;
  logic [NCH-1:0]        prev_q;
  logic [NCH-1:0]        edge_q;
  logic [NCH-1:0]        e_next;
  logic [NCH-1:0]        stretch_q, stretch_d;
  logic [NCH-1:0]        sticky_q, sticky_d;

  assign s = sync_q[NSYNC-1];

  always_comb begin
    if (EDGE_MODE == 0)      e_next = level_q & ~prev_q;
    else if (EDGE_MODE == 1) e_next = ~level_q & prev_q;
    else                     e_next = level_q ^ prev_q;
  end

  // fcnt only advances while below filt_len, so it cannot wrap.
  always_comb begin
    level_d   = level_q;
    stretch_d = '0;
    sticky_d  = sticky_q;
    for (int i = 0; i < NCH; i++) begin
      fcnt_d[i] = '0;
      scnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (fcnt_q[i] >= filt_len_i) level_d[i] = s[i];
        else                         fcnt_d[i]  = fcnt_q[i] + FILT_NB'(1);
      end
      if (e_next[i]) begin
        scnt_d[i]    = STRETCH_NB'(1);
        stretch_d[i] = 1'b1;
        sticky_d[i]  = 1'b1;
      end else begin
        scnt_d[i]    = scnt_q[i] + STRETCH_NB'(scnt_q[i] != '0);
        stretch_d[i] = (scnt_q[i] != '0);
        if (clear_i[i]) sticky_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NSYNC; k++) sync_q[k] <= '0;
      for (int i = 0; i < NCH; i++) begin
        fcnt_q[i] <= '0;
        scnt_q[i] <= '0;
      end
      level_q   <= '0;
      prev_q    <= '0;
      edge_q    <= '0;
      stretch_q <= '0;
      sticky_q  <= '0;
    end else begin
      sync_q[0] <= in_i;
      for (int k = 1; k < NSYNC; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < NCH; i++) begin
        fcnt_q[i] <= fcnt_d[i];
        scnt_q[i] <= scnt_d[i];
      end
      level_q   <= level_d;
      prev_q    <= level_q;
      edge_q    <= e_next;
      stretch_q <= stretch_d;
      sticky_q  <= sticky_d;
    end
  end

  assign level_o   = level_q;
  assign edge_o    = edge_q;
  assign stretch_o = stretch_q;
  assign sticky_o  = sticky_q;
  assign any_o     = |sticky_q;

endmodule

// File: tb/tb_sync_edge_array.sv
// Directed bench for sync_edge_array: three instances (rising, falling, both
// edges) share stimulus; expected values are hand-derived edge counts.
module tb_sync_edge_array;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_v;
  logic [3:0] filt;
  logic [7:0] clr;

  logic [7:0] lvl0, edg0, str0, stk0;
  logic [7:0] lvl1, edg1, str1, stk1;
  logic [7:0] lvl2, edg2, str2, stk2;
  logic       any0, any1, any2;

  int n_chk = 0;
  int n_bad = 0;

  sync_edge_array #(.EDGE_MODE(0)) dut0 (
    .clock_i(clk), .reset_n_i(rst_n), .in_i(in_v), .filt_len_i(filt), .clear_i(clr),
    .level_o(lvl0), .edge_o(edg0), .stretch_o(str0), .sticky_o(stk0), .any_o(any0));
  sync_edge_array #(.EDGE_MODE(1)) dut1 (
    .clock_i(clk), .reset_n_i(rst_n), .in_i(in_v), .filt_len_i(filt), .clear_i(clr),
    .level_o(lvl1), .edge_o(edg1), .stretch_o(str1), .sticky_o(stk1), .any_o(any1));
  sync_edge_array #(.EDGE_MODE(2)) dut2 (
    .clock_i(clk), .reset_n_i(rst_n), .in_i(in_v), .filt_len_i(filt), .clear_i(clr),
    .level_o(lvl2), .edge_o(edg2), .stretch_o(str2), .sticky_o(stk2), .any_o(any2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d0"}, {lvl0, edg0, str0, stk0}, 32'h0);
    chk({tag, "_d1"}, {lvl1, edg1, str1, stk1}, 32'h0);
    chk({tag, "_d2"}, {lvl2, edg2, str2, stk2}, 32'h0);
    chk({tag, "_any"}, {any0, any1, any2}, 32'h0);
  endtask

  // in[0] held high across reset release, filt_len=0, NSYNC=3.
  task automatic run_release();
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("rel_lvl0", lvl0, (k >= 4) ? 8'h01 : 8'h00);
      chk("rel_edg0", edg0, (k == 5) ? 8'h01 : 8'h00);
      chk("rel_str0", str0, (k >= 5 && k <= 12) ? 8'h01 : 8'h00);
      chk("rel_stk0", stk0, (k >= 5) ? 8'h01 : 8'h00);
      chk("rel_any0", any0, (k >= 5) ? 1 : 0);
      chk("rel_lvl1", lvl1, (k >= 4) ? 8'h01 : 8'h00);
      chk("rel_d1", {edg1, str1, stk1}, 0);
      chk("rel_edg2", edg2, (k == 5) ? 8'h01 : 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_v  = 8'h01;
    filt  = 4'd0;
    clr   = 8'h00;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    run_release();

    // Glitch filter, filt_len=3: 3-cycle pulse rejected.
    filt = 4'd3;
    for (int k = 1; k <= 14; k++) begin
      in_v[1] = (k <= 3);
      tick();
      chk("gl3_lvl", lvl0[1], 0);
      chk("gl3_edg", edg2[1], 0);
    end

    // 4-cycle pulse passes: level high edges 7..10, rise strobe 8, fall strobe 12.
    for (int k = 1; k <= 22; k++) begin
      in_v[1] = (k <= 4);
      tick();
      chk("gl4_lvl", lvl0[1], (k >= 7 && k <= 10));
      chk("gl4_rise", edg0[1], (k == 8));
      chk("gl4_fall", edg1[1], (k == 12));
      chk("gl4_both", edg2[1], (k == 8 || k == 12));
      chk("gl4_strf", str1[1], (k >= 12 && k <= 19));
      chk("gl4_stkf", stk1[1], (k >= 12));
    end

    // Retrigger: rising strobes at 5 and 10 give stretch high 5..17.
    filt = 4'd0;
    for (int k = 1; k <= 20; k++) begin
      in_v[2] = (k <= 2) || (k >= 6);
      tick();
      chk("rt_edg", edg0[2], (k == 5 || k == 10));
      chk("rt_str", str0[2], (k >= 5 && k <= 17));
    end

    // Sticky: set beats clear in the same cycle, clear alone then drops it.
    for (int k = 1; k <= 6; k++) begin
      in_v[3] = 1'b1;
      clr = (k == 5) ? 8'h08 : (k == 6) ? 8'hFF : 8'h00;
      tick();
      if (k == 5) begin
        chk("stk_edg", edg0[3], 1);
        chk("stk_win", stk0[3], 1);
        chk("stk_any", any0, 1);
      end
      if (k == 6) begin
        chk("clr_stk0", stk0, 8'h00);
        chk("clr_any0", any0, 0);
        chk("clr_any1", any1, 0);
        chk("clr_any2", any2, 0);
      end
    end
    clr = 8'h00;

    // Reset mid-operation: ch4 stretching, ch5 mid-filter.
    in_v[4] = 1'b1;
    repeat (5) tick();
    chk("mid_edg", edg0[4], 1);
    filt = 4'd5;
    in_v[5] = 1'b1;
    repeat (5) tick();
    chk("mid_str", str0[4], 1);
    chk("mid_lvl5", lvl0[5], 0);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    in_v = 8'h01;
    filt = 4'd0;
    repeat (2) tick();
    chk_all_zero("held_rst");
    rst_n = 1'b1;
    run_release();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
